// File: rtl/ex_sequencer_if.sv
// Execute-stage sequencer bundle: ID handshake, external ALU hookup, MEM handshake and flags.
// master = surrounding pipeline/ALU, slave = ex_sequencer.
interface ex_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_rn;
    logic [DATA_W-1:0] in_rm;
    logic [11:0]       in_imm;
    logic [2:0]        in_icmd;
    logic [3:0]        in_alu_op;
    logic              in_s;
    logic              in_u;
    logic              in_branch;
    logic [3:0]        in_cond;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_op;
    logic              alu_ci;
    logic [DATA_W-1:0] alu_out;
    logic [3:0]        alu_nzcv;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_taken;
    logic [3:0]        flags_nzcv;

    modport master (
        output in_valid, in_rn, in_rm, in_imm, in_icmd, in_alu_op, in_s, in_u,
               in_branch, in_cond, alu_out, alu_nzcv, out_ready,
        input  in_ready, alu_a, alu_b, alu_op, alu_ci, out_valid, out_result,
               out_taken, flags_nzcv
    );

    modport slave (
        input  in_valid, in_rn, in_rm, in_imm, in_icmd, in_alu_op, in_s, in_u,
               in_branch, in_cond, alu_out, alu_nzcv, out_ready,
        output in_ready, alu_a, alu_b, alu_op, alu_ci, out_valid, out_result,
               out_taken, flags_nzcv
    );
endinterface

// File: rtl/ex_sequencer.sv
// Execute-stage controller: shifter operand, one ALU op, NZCV register, branch condition.
// Define EX_SEQ_BARREL_EN for a single-cycle barrel shift instead of the 1-bit/cycle SHIFT state.
module ex_sequencer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    ex_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, EXEC, DONE} state_t;
    localparam logic [1:0] SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rn_q, rn_d, opnd_q, opnd_d, result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        stype_q, stype_d;
    logic [3:0]        op_q, op_d, cond_q, cond_d, flags_q, flags_d;
    logic              s_q, s_d, u_q, u_d, ls_q, ls_d, br_q, br_d;
    logic              cnt_nz_q, cnt_nz_d, shc_q, shc_d, taken_q, taken_d;

    logic [DATA_W-1:0] acc_opnd;
    logic [1:0]        acc_type;
    logic [CNT_W-1:0]  acc_cnt;
    logic              acc_ls;
    logic [DATA_W:0]   step_res;
    logic              is_arith, is_cmp;
    logic [DATA_W-1:0] alu_a_c, alu_b_c;
    logic [3:0]        alu_op_c;
    logic              alu_ci_c;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return cf;
            4'h3:    return !cf;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return cf & !z;
            4'h9:    return !cf | z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z & (n == v);
            4'hD:    return z | (n != v);
            4'hE:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        acc_opnd = bus.in_rm;
        acc_type = bus.in_imm[6:5];
        acc_cnt  = CNT_W'(bus.in_imm[11:7]);
        acc_ls   = 1'b0;
        case (bus.in_icmd)
            3'b001: begin
                acc_opnd = DATA_W'(bus.in_imm[7:0]);
                acc_type = SH_ROR;
                acc_cnt  = CNT_W'({bus.in_imm[11:8], 1'b0});
            end
            3'b010: begin
                acc_opnd = DATA_W'(bus.in_imm);
                acc_type = SH_LSL;
                acc_cnt  = '0;
                acc_ls   = 1'b1;
            end
            3'b011: begin
                acc_type = SH_LSL;
                acc_cnt  = '0;
                acc_ls   = 1'b1;
            end
            default: ;
        endcase
    end

    // Single-bit step; the MSB of step_res is the bit falling out this cycle.
    always_comb begin
        case (stype_q)
            SH_LSL:  step_res = {opnd_q[DATA_W-1], opnd_q[DATA_W-2:0], 1'b0};
            SH_LSR:  step_res = {opnd_q[0], 1'b0, opnd_q[DATA_W-1:1]};
            SH_ASR:  step_res = {opnd_q[0], opnd_q[DATA_W-1], opnd_q[DATA_W-1:1]};
            default: step_res = {opnd_q[0], opnd_q[0], opnd_q[DATA_W-1:1]};
        endcase
    end

`ifdef EX_SEQ_BARREL_EN
    logic [2*DATA_W-1:0] bw;
    logic [DATA_W:0]     barrel_res;

    // Shift in a double-width window so the last bit shifted out lands at a fixed position.
    always_comb begin
        bw         = '0;
        barrel_res = '0;
        case (acc_type)
            SH_LSL: begin
                bw         = {{DATA_W{1'b0}}, acc_opnd} << acc_cnt;
                barrel_res = {bw[DATA_W], bw[DATA_W-1:0]};
            end
            SH_LSR: begin
                bw         = {acc_opnd, {DATA_W{1'b0}}} >> acc_cnt;
                barrel_res = {bw[DATA_W-1], bw[2*DATA_W-1:DATA_W]};
            end
            SH_ASR: begin
                bw         = $signed({acc_opnd, {DATA_W{1'b0}}}) >>> acc_cnt;
                barrel_res = {bw[DATA_W-1], bw[2*DATA_W-1:DATA_W]};
            end
            default: begin
                bw         = {acc_opnd, acc_opnd} >> acc_cnt;
                barrel_res = {bw[DATA_W-1], bw[DATA_W-1:0]};
            end
        endcase
    end
`endif

    assign is_cmp   = (op_q[3:2] == 2'b10);
    assign is_arith = (op_q inside {[4'b0010:4'b0111], 4'b1010, 4'b1011});

    always_comb begin
        state_d  = state_q;
        rn_d     = rn_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        stype_d  = stype_q;
        op_d     = op_q;
        cond_d   = cond_q;
        flags_d  = flags_q;
        s_d      = s_q;
        u_d      = u_q;
        ls_d     = ls_q;
        br_d     = br_q;
        cnt_nz_d = cnt_nz_q;
        shc_d    = shc_q;
        taken_d  = taken_q;
        alu_a_c  = '0;
        alu_b_c  = '0;
        alu_op_c = '0;
        alu_ci_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    rn_d     = bus.in_rn;
                    stype_d  = acc_type;
                    op_d     = bus.in_alu_op;
                    cond_d   = bus.in_cond;
                    s_d      = bus.in_s;
                    u_d      = bus.in_u;
                    ls_d     = acc_ls;
                    br_d     = bus.in_branch;
                    cnt_nz_d = (acc_cnt != '0);
`ifdef EX_SEQ_BARREL_EN
                    opnd_d   = barrel_res[DATA_W-1:0];
                    shc_d    = barrel_res[DATA_W];
                    cnt_d    = '0;
                    state_d  = EXEC;
`else
                    opnd_d   = acc_opnd;
                    shc_d    = 1'b0;
                    cnt_d    = acc_cnt;
                    state_d  = (acc_cnt != '0) ? SHIFT : EXEC;
`endif
                end
            end
            SHIFT: begin
                {shc_d, opnd_d} = step_res;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = EXEC;
            end
            EXEC: begin
                alu_a_c  = rn_q;
                alu_b_c  = opnd_q;
                alu_ci_c = flags_q[1];
                alu_op_c = ls_q ? (u_q ? 4'b0100 : 4'b0010) : op_q;
                result_d = bus.alu_out;
                taken_d  = br_q & cond_pass(cond_q, flags_q);
                // Logical ops take C from the shifter only when a shift really happened.
                if (!ls_q && (is_cmp || s_q)) begin
                    if (is_arith) begin
                        flags_d = bus.alu_nzcv;
                    end else begin
                        flags_d[3:2] = bus.alu_nzcv[3:2];
                        if (cnt_nz_q) flags_d[1] = shc_q;
                    end
                end
                state_d = DONE;
            end
            default: begin
                if (bus.out_ready) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rn_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            stype_q  <= '0;
            op_q     <= '0;
            cond_q   <= '0;
            flags_q  <= '0;
            s_q      <= 1'b0;
            u_q      <= 1'b0;
            ls_q     <= 1'b0;
            br_q     <= 1'b0;
            cnt_nz_q <= 1'b0;
            shc_q    <= 1'b0;
            taken_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rn_q     <= rn_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            stype_q  <= stype_d;
            op_q     <= op_d;
            cond_q   <= cond_d;
            flags_q  <= flags_d;
            s_q      <= s_d;
            u_q      <= u_d;
            ls_q     <= ls_d;
            br_q     <= br_d;
            cnt_nz_q <= cnt_nz_d;
            shc_q    <= shc_d;
            taken_q  <= taken_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = result_q;
    assign bus.out_taken  = taken_q;
    assign bus.flags_nzcv = flags_q;
    assign bus.alu_a      = alu_a_c;
    assign bus.alu_b      = alu_b_c;
    assign bus.alu_op     = alu_op_c;
    assign bus.alu_ci     = alu_ci_c;
endmodule
